pc_fetch: RTL
=============

# pc_fetch

Fetch-stage controller for the 54-instruction MIPS CPU. It owns the program-counter register, whose value feeds the PC+4 adder, and selects the next PC from the adder result, branch/jump targets, the exception vector and EPC. It runs a request/ready handshake with instruction memory and holds the fetched word for the decoder until the decoder consumes it. It also counts retired fetches.

## Interface
Parameters:
- RESET_PC, 32'h0040_0000, PC value loaded on reset.
- EXC_VECTOR, 32'h0000_0004, target for exceptions and for misaligned redirects.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- npc_in  in  32  PC+4 from the adder (driven from pc_out).
- pc_out  out  32  current PC.
- branch_take  in  1  conditional branch taken.
- branch_target  in  32  branch destination.
- jump_take  in  1  j/jal/jr/jalr.
- jump_target  in  32  jump destination.
- exc_take  in  1  syscall/break/teq trap.
- eret_take  in  1  eret.
- epc_in  in  32  EPC from CP0.
- stall  in  1  execute busy (mul/div); blocks advance.
- imem_req  out  1  fetch request.
- imem_addr  out  32  fetch address.
- imem_ready  in  1  imem_rdata valid this cycle.
- imem_rdata  in  32  fetched word.
- instr_out  out  32  held instruction.
- instr_valid  out  1  instr_out is valid.
- instr_ack  in  1  decoder consumes instr_out.
- addr_err  out  1  one-cycle pulse when a misaligned redirect is replaced by EXC_VECTOR.
- fetch_count  out  32  number of completed advances; wraps at 2^32.

## Operation
- States:
  - BOOT: entered on reset; no request. Unconditionally moves to REQ on the next clock.
  - REQ: imem_req=1, imem_addr=pc_out. When imem_ready=1, latch imem_rdata into instr_out and go to HOLD. Otherwise stay in REQ with the address held stable.
  - HOLD: instr_valid=1. Advance when instr_ack=1 and stall=0; on advance, load the PC and go to REQ. Otherwise stay in HOLD with instr_out held.
- Redirect inputs are sampled only on the advance cycle.
- Next-PC priority on advance: exc_take → EXC_VECTOR; else eret_take → epc_in; else jump_take → jump_target; else branch_take → branch_target; else npc_in.
- Alignment: if the selected redirect target has [1:0]≠0, load EXC_VECTOR and pulse addr_err for one cycle. npc_in is not checked.
- fetch_count increments by 1 on each advance and wraps from FFFF_FFFF to 0.
- instr_ack outside HOLD is ignored. Redirect inputs outside the advance cycle are ignored.

## Timing
- Reset values (asserted asynchronously): pc_out=RESET_PC, state=BOOT, imem_req=0, instr_valid=0, instr_out=0, addr_err=0, fetch_count=0.
- imem_addr is combinationally equal to pc_out at all times.
- Zero-wait memory: REQ in cycle N with imem_ready=1 gives instr_valid=1 in cycle N+1.
- Minimum cadence: 2 cycles per instruction (REQ, HOLD). Each memory wait cycle adds 1.
- Advance at the edge ending cycle M: the new pc_out, REQ state and fetch_count+1 are visible in cycle M+1. addr_err is high in cycle M+1 only.
- stall=1 with instr_ack=1 keeps HOLD unchanged; the advance occurs on the first cycle with stall=0 and instr_ack=1.
- Simultaneous exc_take and jump_take: exception wins, no addr_err, even if jump_target is misaligned.
- Reset asserted mid-REQ or mid-HOLD: all registers return to reset values immediately. A memory response arriving during reset is discarded.
- Reset release: BOOT for 1 cycle, and the first imem_req comes in the second cycle after release.

## Test plan
- Reset then zero-wait memory returning 0x2008_0001: pc_out=0x0040_0000; imem_req high in cycle 2; instr_valid high in cycle 3; with ack, pc_out=0x0040_0004 and fetch_count=1.
- imem_ready held low for 3 cycles: imem_req and imem_addr stay stable for 4 cycles, and instr_out is latched only when ready=1.
- In HOLD, stall=1 for 5 cycles with instr_ack=1: no PC change and fetch_count constant; stall drops → one advance.
- Advance with exc_take=1, jump_take=1, jump_target=0x0040_0100: pc_out becomes 0x0000_0004, addr_err=0. Next, eret_take=1 with epc_in=0x0040_0020: pc_out becomes 0x0040_0020.
- branch_take=1 with branch_target=0x0040_0012: pc_out becomes 0x0000_0004 and addr_err is high for exactly one cycle.
- Preload fetch_count near 0xFFFF_FFFF via 2^32-wrap check: the advance from 0xFFFF_FFFF yields 0. Asserting rst_n=0 mid-REQ clears imem_req in the same cycle.

Source files
------------

// File: rtl/pc_fetch.sv
// Fetch-stage controller: owns the PC, runs the imem request/ready handshake,
// holds the fetched word for decode and counts completed advances.
module pc_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0040_0000,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0004
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] npc_in,
  output logic [31:0] pc_out,
  input  logic        branch_take,
  input  logic [31:0] branch_target,
  input  logic        jump_take,
  input  logic [31:0] jump_target,
  input  logic        exc_take,
  input  logic        eret_take,
  input  logic [31:0] epc_in,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr_out,
  output logic        instr_valid,
  input  logic        instr_ack,
  output logic        addr_err,
  output logic [31:0] fetch_count
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t      state;
  state_t      state_next;
  logic        advance;
  logic        fetch_done;
  logic        redirect;
  logic        misaligned;
  logic [31:0] pc_sel;
  logic [31:0] pc_next;

  assign advance    = (state == HOLD) && instr_ack && !stall;
  assign fetch_done = (state == REQ) && imem_ready;

  assign imem_req    = (state == REQ);
  assign imem_addr   = pc_out;
  assign instr_valid = (state == HOLD);

  // The exception vector is trusted; only redirect targets are alignment-checked.
  always_comb begin
    pc_sel   = npc_in;
    redirect = 1'b0;
    if (exc_take) begin
      pc_sel = EXC_VECTOR;
    end else if (eret_take) begin
      pc_sel   = epc_in;
      redirect = 1'b1;
    end else if (jump_take) begin
      pc_sel   = jump_target;
      redirect = 1'b1;
    end else if (branch_take) begin
      pc_sel   = branch_target;
      redirect = 1'b1;
    end
  end

  assign misaligned = redirect && (pc_sel[1:0] != 2'b00);
  assign pc_next    = misaligned ? EXC_VECTOR : pc_sel;

  always_comb begin
    state_next = state;
    case (state)
      BOOT:    state_next = REQ;
      REQ:     if (imem_ready) state_next = HOLD;
      HOLD:    if (advance) state_next = REQ;
      default: state_next = BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= BOOT;
    end else begin
      state <= state_next;
    end
  end

  // addr_err only rises on an advance, and the cycle after an advance is REQ,
  // so it naturally lasts exactly one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_out      <= RESET_PC;
      instr_out   <= 32'h0;
      addr_err    <= 1'b0;
      fetch_count <= 32'h0;
    end else begin
      addr_err <= advance && misaligned;
      if (fetch_done) begin
        instr_out <= imem_rdata;
      end
      if (advance) begin
        pc_out      <= pc_next;
        fetch_count <= fetch_count + 32'd1;
      end
    end
  end

endmodule
